// File: rtl/color_uart_reporter_if.sv
// Signal bundle between the colour-detection side and the UART reporter.
// The master drives the colour code; the slave (the reporter) drives everything else.
interface color_uart_reporter_if;
  logic [1:0] color;
  logic       tx;
  logic       busy;
  logic [1:0] stable_color;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [1:0] dbg_state;

  // No valid/ready pair here: color is sampled every clock. Events pass through an
  // internal FIFO that accepts a push when not full or when a pop happens in the same
  // cycle. An event is popped only while the TX FSM is in IDLE and the count is non-zero.
  modport master (output color,
                  input  tx, busy, stable_color, fifo_count, overflow, dbg_state);
  modport slave  (input  color,
                  output tx, busy, stable_color, fifo_count, overflow, dbg_state);
endinterface

// File: rtl/color_uart_reporter.sv
// Debounces a 2-bit colour code, queues each newly stable colour as an event, and
// reports every event over UART 8N1 as an ASCII letter followed by LF.
module color_uart_reporter #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CLKS_PER_BIT  = 104,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic clk_1MHz,
  input  logic reset,
  color_uart_reporter_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    FULL     = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  function automatic logic [7:0] letter(input logic [1:0] c);
    case (c)
      2'd1:    letter = 8'h52;
      2'd2:    letter = 8'h47;
      2'd3:    letter = 8'h42;
      default: letter = 8'h00;
    endcase
  endfunction

  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [1:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          byte_idx_q, byte_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          push, push_ok, pop;

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    push       = 1'b0;

    if (bus.color != cand_q) begin
      cand_d = bus.color;
      cnt_d  = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      // Only the edge that reaches the threshold can change stable_color.
      if (cnt_q == CNT_MAX - CW'(1) && cand_q != stable_q) begin
        stable_d = cand_q;
        push     = (cand_q != 2'd0);
      end
    end

    pop     = (state_q == IDLE) && (count_q != 3'd0);
    push_ok = push && ((count_q != FULL) || pop);
    if (push && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      mem_d[wr_ptr_q] = cand_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d    = letter(mem_q[rd_ptr_q]);
          byte_idx_d = 1'b0;
          baud_d     = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else baud_d = baud_q + 1'b1;
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else baud_d = baud_q + 1'b1;
      end
      default: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (!byte_idx_q) begin
            shreg_d    = 8'h0A;
            byte_idx_d = 1'b1;
            state_d    = START;
          end else state_d = IDLE;
        end else baud_d = baud_q + 1'b1;
      end
    endcase

    // tx and busy follow the current state one clock later, so both start together.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      cand_q     <= 2'd0;
      cnt_q      <= '0;
      stable_q   <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 3'd0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      shreg_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.busy         = busy_q;
  assign bus.stable_color = stable_q;
  assign bus.fifo_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.dbg_state    = state_q;
endmodule
